// File: rtl/parse_act_ram_mp_pkg.sv
// Shared types and helpers for the parser action table: FSM states,
// parameter range limits and lane slicing.
package parse_act_ram_mp_pkg;

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } state_t;

   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 3;
   localparam int NUM_RD_MIN = 1;
   localparam int NUM_RD_MAX = 4;

   function automatic bit rd_lat_ok(input int lat);
      return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
   endfunction

   function automatic bit num_rd_ok(input int n);
      return (n >= NUM_RD_MIN) && (n <= NUM_RD_MAX);
   endfunction

   // Low bit of lane `lane` inside a flat bus of `width`-bit lanes.
   function automatic int lane_lsb(input int lane, input int width);
      return lane * width;
   endfunction

endpackage

// File: rtl/parse_act_rd_pipe.sv
// One read port: write-first bypass at the request cycle, then an RD_LAT-deep
// valid/data pipeline whose output data holds the last valid result.
module parse_act_rd_pipe #(
   parameter int ADDR_BITS = 5,
   parameter int DATA_BITS = 160,
   parameter int RD_LAT    = 2
) (
   input  logic                 clk,
   input  logic                 aresetn,
   input  logic                 req,
   input  logic [ADDR_BITS-1:0] addr,
   input  logic [DATA_BITS-1:0] mem_data,
   input  logic                 wr_en,
   input  logic [ADDR_BITS-1:0] wr_addr,
   input  logic [DATA_BITS-1:0] wr_data,
   output logic                 vld,
   output logic [DATA_BITS-1:0] data
);

   logic [RD_LAT-1:0]    vld_q;
   logic [DATA_BITS-1:0] data_q [RD_LAT];
   logic [DATA_BITS-1:0] fresh;

   assign fresh = (wr_en && (wr_addr == addr)) ? wr_data : mem_data;

   // Data stages only advance behind a valid, so the tail holds its last result.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         vld_q <= '0;
         for (int s = 0; s < RD_LAT; s++) data_q[s] <= '0;
      end else begin
         vld_q[0] <= req;
         if (req) data_q[0] <= fresh;
         for (int s = 1; s < RD_LAT; s++) begin
            vld_q[s] <= vld_q[s-1];
            if (vld_q[s-1]) data_q[s] <= data_q[s-1];
         end
      end
   end

   assign vld  = vld_q[RD_LAT-1];
   assign data = data_q[RD_LAT-1];

endmodule

// File: rtl/parse_act_ram_mp.sv
// Parser action table: one control write port, NUM_RD pipelined lookup lanes,
// a single-outstanding readback port and a post-reset zeroing sweep.
module parse_act_ram_mp
   import parse_act_ram_mp_pkg::*;
#(
   parameter int ADDR_BITS = 5,
   parameter int DATA_BITS = 160,
   parameter int NUM_RD    = 2,
   parameter int RD_LAT    = 2
) (
   input  logic                          clk,
   input  logic                          aresetn,
   input  logic                          wr_en,
   input  logic [ADDR_BITS-1:0]          wr_addr,
   input  logic [DATA_BITS-1:0]          wr_data,
   input  logic [NUM_RD-1:0]             rd_req,
   input  logic [NUM_RD*ADDR_BITS-1:0]   rd_addr,
   output logic [NUM_RD-1:0]             rd_vld,
   output logic [NUM_RD*DATA_BITS-1:0]   rd_data,
   input  logic                          cfg_rd_req,
   input  logic [ADDR_BITS-1:0]          cfg_rd_addr,
   output logic                          cfg_rd_ack,
   output logic [DATA_BITS-1:0]          cfg_rd_data,
   output logic                          init_busy
);

   localparam int                   DEPTH     = 2**ADDR_BITS;
   localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;

   if (!rd_lat_ok(RD_LAT)) begin : g_bad_rd_lat
      $error("parse_act_ram_mp: RD_LAT out of range");
   end
   if (!num_rd_ok(NUM_RD)) begin : g_bad_num_rd
      $error("parse_act_ram_mp: NUM_RD out of range");
   end

   state_t               state_q, state_d;
   logic [ADDR_BITS-1:0] cnt_q, cnt_d;
   logic                 run;

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= ST_INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // NOTE: defaults first in always_comb so no path leaves a signal unassigned (no latch).
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_INIT: begin
            if (cnt_q == LAST_ADDR) state_d = ST_RUN;
            else                    cnt_d   = cnt_q + ADDR_BITS'(1);
         end
         ST_RUN:  ;
         default: state_d = ST_INIT;
      endcase
   end

   assign run       = (state_q == ST_RUN);
   assign init_busy = !run;

   // Single write port: the clearing sweep owns it until RUN.
   logic                 wr_run;
   logic                 mem_we;
   logic [ADDR_BITS-1:0] mem_waddr;
   logic [DATA_BITS-1:0] mem_wdata;
   logic [DATA_BITS-1:0] mem [DEPTH];

   assign wr_run    = run & wr_en;
   assign mem_we    = run ? wr_en   : 1'b1;
   assign mem_waddr = run ? wr_addr : cnt_q;
   assign mem_wdata = run ? wr_data : '0;

   // NOTE: storage has no reset branch; the INIT sweep clears it so it can map to RAM.
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_lane
      logic [ADDR_BITS-1:0] lane_addr;
      logic                 lane_vld;
      logic [DATA_BITS-1:0] lane_data;

      assign lane_addr = rd_addr[lane_lsb(i, ADDR_BITS) +: ADDR_BITS];

      parse_act_rd_pipe #(
         .ADDR_BITS (ADDR_BITS),
         .DATA_BITS (DATA_BITS),
         .RD_LAT    (RD_LAT)
      ) u_pipe (
         .clk      (clk),
         .aresetn  (aresetn),
         .req      (run & rd_req[i]),
         .addr     (lane_addr),
         .mem_data (mem[lane_addr]),
         .wr_en    (wr_run),
         .wr_addr  (wr_addr),
         .wr_data  (wr_data),
         .vld      (lane_vld),
         .data     (lane_data)
      );

      assign rd_vld[i]                                  = lane_vld;
      assign rd_data[lane_lsb(i, DATA_BITS) +: DATA_BITS] = lane_data;
   end

   // Readback: one in flight; the ack cycle frees the slot for a new request.
   logic cfg_pend_q;
   logic cfg_accept;

   assign cfg_accept = run & cfg_rd_req & (!cfg_pend_q | cfg_rd_ack);

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn)        cfg_pend_q <= 1'b0;
      else if (cfg_accept) cfg_pend_q <= 1'b1;
      else if (cfg_rd_ack) cfg_pend_q <= 1'b0;
   end

   parse_act_rd_pipe #(
      .ADDR_BITS (ADDR_BITS),
      .DATA_BITS (DATA_BITS),
      .RD_LAT    (RD_LAT)
   ) u_cfg_pipe (
      .clk      (clk),
      .aresetn  (aresetn),
      .req      (cfg_accept),
      .addr     (cfg_rd_addr),
      .mem_data (mem[cfg_rd_addr]),
      .wr_en    (wr_run),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .vld      (cfg_rd_ack),
      .data     (cfg_rd_data)
   );

endmodule

// File: doc/parse_act_ram_mp.md
Name: parse_act_ram_mp

Overview:
- Parser action table storage for the Menshen-style packet parser: one write port from the control path and NUM_RD independent lookup ports for parallel parser lanes.
- Adds over the single-port action RAM:
  - a configurable registered read latency with valid tracking;
  - write-first collision bypass;
  - a post-reset zero-initialisation sweep;
  - a handshaked control-plane readback port.
- Sits between the config/control module (writer, readback) and the parser lanes (lookups).

Parameters:
- ADDR_BITS, 5, table index width; depth = 2**ADDR_BITS.
- DATA_BITS, 160, action entry width.
- NUM_RD, 2, number of lookup lanes, 1..4.
- RD_LAT, 2, lookup and readback latency in cycles, 1..3.

Ports:
- clk  in  1  sole clock.
- aresetn  in  1  asynchronous active-low reset.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_BITS  write index.
- wr_data  in  DATA_BITS  write entry.
- rd_req  in  NUM_RD  per-lane lookup strobe.
- rd_addr  in  NUM_RD*ADDR_BITS  lane i index at bits [i*ADDR_BITS +: ADDR_BITS].
- rd_vld  out  NUM_RD  per-lane result valid.
- rd_data  out  NUM_RD*DATA_BITS  lane i result at bits [i*DATA_BITS +: DATA_BITS].
- cfg_rd_req  in  1  readback request pulse.
- cfg_rd_addr  in  ADDR_BITS  readback index.
- cfg_rd_ack  out  1  readback done pulse.
- cfg_rd_data  out  DATA_BITS  readback entry, held until the next ack.
- init_busy  out  1  high while the clear sweep runs.

Behaviour:
- Reset, asynchronous assert:
  - rd_vld=0, rd_data=0, cfg_rd_ack=0, cfg_rd_data=0.
  - init_busy=1, FSM=INIT, sweep counter=0.
  - All pipeline valids cleared. Storage contents are not reset asynchronously.
- FSM states:
  - INIT: one entry per cycle at counter address is written with 0; counter increments. At counter == 2**ADDR_BITS-1, the write completes, FSM goes to RUN and init_busy drops the next cycle. Sweep takes exactly 2**ADDR_BITS cycles after reset release.
  - RUN: normal operation. The only exit is reset.
- During INIT, wr_en, rd_req and cfg_rd_req are ignored: no write, no rd_vld, no ack, no queued effect.
- Write: in RUN with wr_en=1, mem[wr_addr]<=wr_data at the clock edge.
- Lookup:
  - rd_req[i]=1 at edge N gives rd_vld[i]=1 and rd_data[i]=entry on the cycle after edge N+RD_LAT-1 (RD_LAT=1: visible the cycle right after the request).
  - Fully pipelined: back-to-back requests every cycle on every lane; results return in order.
- rd_data when invalid: holds the last valid value (no clear). rd_vld is a single-cycle pulse per request.
- Collision: if wr_en and rd_req[i] in the same cycle with equal addresses, lane i returns wr_data (write-first). A write after the request cycle never alters that in-flight result.
- Multiple lanes may read the same address in one cycle; each gets an identical result.
- Readback (cfg_rd_*):
  - Single-outstanding. A cfg_rd_req accepted in RUN when idle sets pending.
  - cfg_rd_ack pulses exactly once, RD_LAT cycles later, with cfg_rd_data loaded the same cycle.
  - cfg_rd_req while pending is dropped, not queued.
  - Write-first bypass applies as for lookup lanes.
  - A new request may be accepted in the cycle cfg_rd_ack is high.
- Reset mid-operation: all in-flight lookups and the pending readback are discarded (no vld or ack after release); sweep restarts from 0.
- Widths: counter is ADDR_BITS+1 bits internally, or terminal-compared at ADDR_BITS; no wrap past the last entry.

Decomposition:
- Shared package holds:
  - the FSM state enum (INIT, RUN);
  - a RD_LAT range check constant;
  - lane slice helper localparams.
- One natural sub-module: parse_act_rd_pipe, instantiated per lane plus once for readback.
  - Input: req, addr, collision-bypass data.
  - Output: RD_LAT-stage valid/data pipeline.
- Storage array plus INIT FSM stays in the top.

Test Plan:
- Reset release, depth 32 -> init_busy high exactly 32 cycles. A readback of addr 31 after that returns 0; rd_req during INIT yields no rd_vld.
- Write addr 5 = 0xA5..A5, then lane0 and lane1 both read addr 5 at edge N -> both rd_vld pulse at N+RD_LAT with 0xA5..A5.
- Same-cycle wr_en addr 7 = 0x1234 and rd_req lane1 addr 7 (old value 0x99) -> lane1 returns 0x1234. A write of 0x5555 to addr 7 one cycle after the request does not change that result.
- Lane0 requests addr 0,1,2,3 on consecutive cycles after distinct writes -> four consecutive rd_vld pulses carrying entries 0..3 in order.
- cfg_rd_req addr 9, then a second req the next cycle addr 10 -> exactly one ack after RD_LAT with entry 9. A req in the ack cycle for addr 10 -> second ack with entry 10.
- aresetn low while lanes have in-flight requests and a readback is pending -> no rd_vld or cfg_rd_ack after release; a fresh 32-cycle sweep follows.
